// File: rtl/sample_discriminator_config_sequencer.sv
// Shadow/active configuration store for the sample discriminator. A commit swaps the shadow set in at once,
// holds the discriminator in reset, then drains long enough to refill its pre-trigger history.
module sample_discriminator_config_sequencer #(
  parameter int CHANNELS         = 8,
  parameter int TX_CHANNELS      = 8,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int MAX_DELAY_CYCLES = 64,
  parameter int HOLD_CYCLES      = 4,
  localparam int TIMER_BITS      = $clog2(MAX_DELAY_CYCLES),
  localparam int NUM_SRC         = CHANNELS + TX_CHANNELS,
  localparam int SRC_BITS        = $clog2(NUM_SRC),
  localparam int CFG_W           = 2 * CHANNELS * SAMPLE_WIDTH,
  localparam int THR_W           = CHANNELS * 2 * SAMPLE_WIDTH,
  localparam int DLY_W           = CHANNELS * 3 * TIMER_BITS,
  localparam int SRC_W           = CHANNELS * SRC_BITS
) (
  input  logic                i_adc_clk,
  input  logic                i_adc_reset,
  input  logic [1:0]          i_cfg_sel,
  input  logic [CFG_W-1:0]    i_cfg_data,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic                i_commit_valid,
  output logic                o_commit_ready,
  output logic [THR_W-1:0]    o_thresholds,
  output logic [DLY_W-1:0]    o_delays,
  output logic [SRC_W-1:0]    o_trigger_sources,
  output logic [CHANNELS-1:0] o_bypass_mask,
  output logic                o_disc_reset_state,
  output logic                o_armed,
  output logic                o_busy,
  output logic                o_cfg_error,
  output logic [15:0]         o_epoch
);

  localparam int CNT_MAX = (HOLD_CYCLES > MAX_DELAY_CYCLES) ? HOLD_CYCLES : MAX_DELAY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic thresholds_ok(input logic [THR_W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      ok = ok & ($signed(d[c*2*SAMPLE_WIDTH +: SAMPLE_WIDTH]) <=
                 $signed(d[c*2*SAMPLE_WIDTH + SAMPLE_WIDTH +: SAMPLE_WIDTH]));
    end
    return ok;
  endfunction

  function automatic logic sources_ok(input logic [SRC_W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      ok = ok & (32'(d[c*SRC_BITS +: SRC_BITS]) < 32'(NUM_SRC));
    end
    return ok;
  endfunction

  function automatic logic [SRC_W-1:0] default_sources();
    logic [SRC_W-1:0] s;
    s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s[c*SRC_BITS +: SRC_BITS] = SRC_BITS'(c);
    end
    return s;
  endfunction

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;

  logic [THR_W-1:0]     r_sh_thr,  w_sh_thr;
  logic [DLY_W-1:0]     r_sh_dly,  w_sh_dly;
  logic [SRC_W-1:0]     r_sh_src,  w_sh_src;
  logic [CHANNELS-1:0]  r_sh_mask, w_sh_mask;

  logic [THR_W-1:0]     r_thr;
  logic [DLY_W-1:0]     r_dly;
  logic [SRC_W-1:0]     r_src;
  logic [CHANNELS-1:0]  r_mask;
  logic                 r_armed;
  logic                 r_cfg_error;
  logic [15:0]          r_epoch;

  logic                 w_idle;
  logic                 w_cfg_fire;
  logic                 w_commit_fire;
  logic                 w_wr_ok;
  logic                 w_drain_done;

  assign w_idle        = (r_state == S_IDLE);
  assign w_cfg_fire    = i_cfg_valid & w_idle;
  assign w_commit_fire = i_commit_valid & w_idle;
  assign w_drain_done  = (r_state == S_DRAIN) && (r_cnt == CNT_W'(1));

  // Write validation
  always_comb begin
    w_wr_ok = 1'b1;
    case (i_cfg_sel)
      2'd0:    w_wr_ok = thresholds_ok(i_cfg_data[THR_W-1:0]);
      2'd2:    w_wr_ok = sources_ok(i_cfg_data[SRC_W-1:0]);
      default: w_wr_ok = 1'b1;
    endcase
  end

  // Shadow set including this cycle's accepted write, so a same-cycle commit picks it up
  always_comb begin
    w_sh_thr  = r_sh_thr;
    w_sh_dly  = r_sh_dly;
    w_sh_src  = r_sh_src;
    w_sh_mask = r_sh_mask;
    if (w_cfg_fire && w_wr_ok) begin
      case (i_cfg_sel)
        2'd0:    w_sh_thr  = i_cfg_data[THR_W-1:0];
        2'd1:    w_sh_dly  = i_cfg_data[DLY_W-1:0];
        2'd2:    w_sh_src  = i_cfg_data[SRC_W-1:0];
        2'd3:    w_sh_mask = i_cfg_data[CHANNELS-1:0];
        default: w_sh_thr  = r_sh_thr;
      endcase
    end else begin
      w_sh_thr = r_sh_thr;
    end
  end

  // State register and shared down-counter
  always_ff @(posedge i_adc_clk or posedge i_adc_reset) begin
    if (i_adc_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; each phase exits when the counter reads 1
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_commit_fire) begin
          w_state_next = S_HOLD;
          w_cnt_next   = CNT_W'(HOLD_CYCLES);
        end else begin
          w_cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_DRAIN;
          w_cnt_next   = CNT_W'(MAX_DELAY_CYCLES);
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    o_cfg_ready        = 1'b0;
    o_commit_ready     = 1'b0;
    o_busy             = 1'b1;
    o_disc_reset_state = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cfg_ready    = 1'b1;
        o_commit_ready = 1'b1;
        o_busy         = 1'b0;
      end
      S_HOLD:  o_disc_reset_state = 1'b1;
      S_DRAIN: o_disc_reset_state = 1'b0;
      default: o_busy             = 1'b0;
    endcase
  end

  // Shadow and active configuration; active only moves on an accepted commit
  always_ff @(posedge i_adc_clk or posedge i_adc_reset) begin
    if (i_adc_reset) begin
      r_sh_thr  <= '0;
      r_sh_dly  <= '0;
      r_sh_src  <= default_sources();
      r_sh_mask <= '1;
      r_thr     <= '0;
      r_dly     <= '0;
      r_src     <= default_sources();
      r_mask    <= '1;
    end else begin
      r_sh_thr  <= w_sh_thr;
      r_sh_dly  <= w_sh_dly;
      r_sh_src  <= w_sh_src;
      r_sh_mask <= w_sh_mask;
      if (w_commit_fire) begin
        r_thr  <= w_sh_thr;
        r_dly  <= w_sh_dly;
        r_src  <= w_sh_src;
        r_mask <= w_sh_mask;
      end
    end
  end

  // Status: armed, sticky error (a rejection in the commit cycle is not lost), epoch
  always_ff @(posedge i_adc_clk or posedge i_adc_reset) begin
    if (i_adc_reset) begin
      r_armed     <= 1'b0;
      r_cfg_error <= 1'b0;
      r_epoch     <= 16'd0;
    end else begin
      if (w_commit_fire) begin
        r_armed <= 1'b0;
      end else if (w_drain_done) begin
        r_armed <= 1'b1;
      end
      if (w_cfg_fire && !w_wr_ok) begin
        r_cfg_error <= 1'b1;
      end else if (w_commit_fire) begin
        r_cfg_error <= 1'b0;
      end
      if (w_drain_done) begin
        r_epoch <= r_epoch + 16'd1;
      end
    end
  end

  assign o_thresholds      = r_thr;
  assign o_delays          = r_dly;
  assign o_trigger_sources = r_src;
  assign o_bypass_mask     = r_mask;
  assign o_armed           = r_armed;
  assign o_cfg_error       = r_cfg_error;
  assign o_epoch           = r_epoch;

endmodule

// File: tb/tb_sample_discriminator_config_sequencer.sv
// Directed bench for sample_discriminator_config_sequencer. A second instance with fewer trigger sources
// exercises the out-of-range source rejection, which the default 16-source build cannot encode.
module tb_sample_discriminator_config_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cfg_sel;
  logic [255:0] cfg_data;
  logic         cfg_valid;
  logic         commit_valid;

  logic         a_cfg_ready, a_commit_ready, a_disc, a_armed, a_busy, a_err;
  logic [255:0] a_thr;
  logic [143:0] a_dly;
  logic [31:0]  a_src;
  logic [7:0]   a_mask;
  logic [15:0]  a_epoch;

  logic         b_cfg_ready, b_commit_ready, b_disc, b_armed, b_busy, b_err;
  logic [255:0] b_thr;
  logic [143:0] b_dly;
  logic [31:0]  b_src;
  logic [7:0]   b_mask;
  logic [15:0]  b_epoch;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sample_discriminator_config_sequencer u_dut (
    .i_adc_clk(clk), .i_adc_reset(rst), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(a_cfg_ready), .i_commit_valid(commit_valid),
    .o_commit_ready(a_commit_ready), .o_thresholds(a_thr), .o_delays(a_dly),
    .o_trigger_sources(a_src), .o_bypass_mask(a_mask), .o_disc_reset_state(a_disc),
    .o_armed(a_armed), .o_busy(a_busy), .o_cfg_error(a_err), .o_epoch(a_epoch)
  );

  sample_discriminator_config_sequencer #(.TX_CHANNELS(4)) u_dut_tx4 (
    .i_adc_clk(clk), .i_adc_reset(rst), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(b_cfg_ready), .i_commit_valid(commit_valid),
    .o_commit_ready(b_commit_ready), .o_thresholds(b_thr), .o_delays(b_dly),
    .o_trigger_sources(b_src), .o_bypass_mask(b_mask), .o_disc_reset_state(b_disc),
    .o_armed(b_armed), .o_busy(b_busy), .o_cfg_error(b_err), .o_epoch(b_epoch)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [255:0] thr_a;
  logic [143:0] dly_a;
  logic [255:0] thr_bad;

  initial begin
    rst          = 1'b1;
    cfg_sel      = 2'd0;
    cfg_data     = '0;
    cfg_valid    = 1'b0;
    commit_valid = 1'b0;
    thr_a        = {8{32'h00C8FF9C}};
    dly_a        = {8{18'h3F081}};
    thr_bad      = '0;
    thr_bad[127:96] = 32'h000A0032;
    run(3);
    rst = 1'b0;
    tick();

    // Reset defaults
    chk("rst_mask",    a_mask, 8'hFF);
    chk("rst_src",     a_src, 32'h76543210);
    chk("rst_thr",     a_thr, 256'd0);
    chk("rst_dly",     a_dly, 144'd0);
    chk("rst_armed",   a_armed, 1'b0);
    chk("rst_busy",    a_busy, 1'b0);
    chk("rst_epoch",   a_epoch, 16'd0);
    chk("rst_err",     a_err, 1'b0);
    chk("rst_disc",    a_disc, 1'b0);
    chk("rst_ready",   {a_cfg_ready, a_commit_ready}, 2'b11);

    // Threshold write then commit; timing of hold/drain/arm
    cfg_sel = 2'd0; cfg_data = thr_a; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("thr_shadow_only", a_thr, 256'd0);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    chk("t1_thr",   a_thr, thr_a);
    chk("t1_disc",  a_disc, 1'b1);
    chk("t1_busy",  a_busy, 1'b1);
    chk("t1_armed", a_armed, 1'b0);
    chk("t1_ready", {a_cfg_ready, a_commit_ready}, 2'b00);
    run(3);
    chk("t4_disc",  a_disc, 1'b1);
    tick();
    chk("t5_disc",  a_disc, 1'b0);
    chk("t5_busy",  a_busy, 1'b1);
    run(63);
    chk("t68_busy",  a_busy, 1'b1);
    chk("t68_armed", a_armed, 1'b0);
    chk("t68_epoch", a_epoch, 16'd0);
    tick();
    chk("t69_busy",  a_busy, 1'b0);
    chk("t69_armed", a_armed, 1'b1);
    chk("t69_epoch", a_epoch, 16'd1);

    // Rejected writes leave shadow alone; error sticky until commit
    cfg_sel = 2'd2; cfg_data = 256'h76C43210; cfg_valid = 1'b1;
    tick();
    chk("src12_ok_16src",  a_err, 1'b0);
    chk("src12_rej_12src", b_err, 1'b1);
    cfg_sel = 2'd0; cfg_data = thr_bad;
    tick();
    chk("thr_rej_err", a_err, 1'b1);
    cfg_sel = 2'd1; cfg_data = {112'd0, dly_a};
    tick();
    cfg_valid = 1'b0;
    chk("err_sticky", a_err, 1'b1);
    commit_valid = 1'b1;
    tick();
    chk("rej_thr_kept",  a_thr, thr_a);
    chk("dly_applied",   a_dly, dly_a);
    chk("src_applied",   a_src, 32'h76C43210);
    chk("src_rej_kept",  b_src, 32'h76543210);
    chk("err_cleared",   {a_err, b_err}, 2'b00);

    // Writes and commits presented while busy wait for IDLE
    cfg_sel = 2'd3; cfg_data = 256'hA5; cfg_valid = 1'b1;
    run(10);
    chk("bp_ready", {a_cfg_ready, a_commit_ready}, 2'b00);
    chk("bp_mask",  a_mask, 8'hFF);
    run(57);
    chk("bp_t68_busy", a_busy, 1'b1);
    tick();
    chk("bp_t69_idle",  {a_busy, a_armed, a_cfg_ready}, 3'b011);
    chk("bp_t69_epoch", a_epoch, 16'd2);
    chk("bp_t69_mask",  a_mask, 8'hFF);
    tick();
    cfg_valid = 1'b0; commit_valid = 1'b0;
    chk("bp_accept_mask", a_mask, 8'hA5);
    chk("bp_accept_st",   {a_busy, a_armed, a_disc}, 3'b101);
    run(67);
    tick();
    chk("bp_epoch", a_epoch, 16'd3);

    // Same-cycle write+commit, then back-to-back commit
    cfg_sel = 2'd3; cfg_data = 256'h0F; cfg_valid = 1'b1; commit_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("same_cycle_mask", a_mask, 8'h0F);
    chk("same_cycle_busy", a_busy, 1'b1);
    run(67);
    tick();
    chk("b2b_first_done", {a_busy, a_armed}, 2'b01);
    chk("b2b_epoch4",     a_epoch, 16'd4);
    tick();
    commit_valid = 1'b0;
    chk("b2b_restart", {a_busy, a_armed}, 2'b10);
    run(67);
    tick();
    chk("b2b_epoch5", a_epoch, 16'd5);

    // Reset in DRAIN aborts and discards shadow
    cfg_sel = 2'd0; cfg_data = {8{32'h00010001}}; cfg_valid = 1'b1; commit_valid = 1'b1;
    tick();
    cfg_valid = 1'b0; commit_valid = 1'b0;
    chk("pre_rst_thr", a_thr, {8{32'h00010001}});
    run(20);
    rst = 1'b1;
    #2;
    chk("mid_rst_mask",  a_mask, 8'hFF);
    chk("mid_rst_thr",   a_thr, 256'd0);
    chk("mid_rst_src",   a_src, 32'h76543210);
    chk("mid_rst_state", {a_busy, a_disc, a_armed}, 3'b000);
    chk("mid_rst_epoch", a_epoch, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    chk("empty_commit_thr",  a_thr, 256'd0);
    chk("empty_commit_busy", a_busy, 1'b1);
    run(67);
    chk("empty_commit_t68", a_busy, 1'b1);
    tick();
    chk("empty_commit_done", {a_busy, a_armed}, 2'b01);
    chk("empty_commit_epoch", a_epoch, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
